// File: rtl/hc21_ste_pkg.sv
// Shared STE command codes, controller state encoding and command decode helper
// for the HC21 STE cycle controller.
package hc21_ste_pkg;

  localparam logic [2:0] CM_NONE   = 3'b000;
  localparam logic [2:0] CM_IACK   = 3'b010;
  localparam logic [2:0] CM_IO_WR  = 3'b100;
  localparam logic [2:0] CM_IO_RD  = 3'b101;
  localparam logic [2:0] CM_MEM_WR = 3'b110;
  localparam logic [2:0] CM_MEM_RD = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_END   = 3'd3,
    ST_RECOV = 3'd4
  } state_e;

  // Interrupt acknowledge is IORQ* together with M1*; otherwise WR* picks the direction.
  function automatic logic [2:0] cm_select(input logic iorq_n, input logic m1_n, input logic wr_n);
    logic [2:0] cm;
    if (!iorq_n && !m1_n) begin
      cm = CM_IACK;
    end else if (!iorq_n) begin
      cm = wr_n ? CM_IO_RD : CM_IO_WR;
    end else begin
      cm = wr_n ? CM_MEM_RD : CM_MEM_WR;
    end
    return cm;
  endfunction

endpackage

// File: rtl/hc21_ste_cycle_ctrl_if.sv
// Z80 control pins and STE backplane strobes seen by the HC21 cycle controller.
// master: the controller itself; slave: the CPU/backplane side driving it.
interface hc21_ste_cycle_ctrl_if;
  logic       cpu_mreq_n;
  logic       cpu_iorq_n;
  logic       cpu_rd_n;
  logic       cpu_wr_n;
  logic       cpu_m1_n;
  logic       cpu_rfsh_n;
  logic       onboard_n;
  logic       ste_datack_n;
  logic       ste_tfrerr_n;
  logic       err_clr;
  logic       cpu_wait_n;
  logic [2:0] ste_cm;
  logic       ste_adrstb_n;
  logic       ste_datstb_n;
  logic       bufout;
  logic       bus_err;

  modport master (
    input  cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n,
    input  onboard_n, ste_datack_n, ste_tfrerr_n, err_clr,
    output cpu_wait_n, ste_cm, ste_adrstb_n, ste_datstb_n, bufout, bus_err
  );

  modport slave (
    output cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n,
    output onboard_n, ste_datack_n, ste_tfrerr_n, err_clr,
    input  cpu_wait_n, ste_cm, ste_adrstb_n, ste_datstb_n, bufout, bus_err
  );
endinterface

// File: rtl/hc21_ste_sync2.sv
// Two-flop synchronizer for active-low asynchronous backplane replies; idles high.
module hc21_ste_sync2 (
  input  logic sysclk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hc21_ste_cycle_ctrl.sv
// HC21 STE cycle controller: runs each off-board Z80 access as a full STE bus cycle.
// Define HC21_STE_TIMEOUT_EN to add the DATA-phase watchdog (TIMEOUT_CYC).
module hc21_ste_cycle_ctrl
  import hc21_ste_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
`ifdef HC21_STE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input logic                   sysclk,
  input logic                   reset_n,
  hc21_ste_cycle_ctrl_if.master bus
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cm_q, cm_d;
  logic       adrstb_n_q, adrstb_n_d;
  logic       datstb_n_q, datstb_n_d;
  logic       bufout_q, bufout_d;
  logic       bus_err_q, bus_err_d;
  logic       err_set_s;
  logic       req_s;
  logic       iack_s;
  logic       ack_s;
  logic       err_s;
`ifdef HC21_STE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_q, tmo_d;
`endif

  hc21_ste_sync2 u_sync_ack (.sysclk(sysclk), .reset_n(reset_n), .d(bus.ste_datack_n), .q(ack_s));
  hc21_ste_sync2 u_sync_err (.sysclk(sysclk), .reset_n(reset_n), .d(bus.ste_tfrerr_n), .q(err_s));

  // Off-board request decode; refresh cycles never reach the backplane.
  always_comb begin
    req_s  = bus.onboard_n &
             ((~bus.cpu_mreq_n & bus.cpu_rfsh_n & (~bus.cpu_rd_n | ~bus.cpu_wr_n)) |
              (~bus.cpu_iorq_n & (~bus.cpu_rd_n | ~bus.cpu_wr_n | ~bus.cpu_m1_n)));
    iack_s = ~bus.cpu_iorq_n & ~bus.cpu_m1_n;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cm_d       = cm_q;
    adrstb_n_d = adrstb_n_q;
    datstb_n_d = datstb_n_q;
    bufout_d   = bufout_q;
    err_set_s  = 1'b0;
`ifdef HC21_STE_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d    = ST_ADDR;
          cm_d       = cm_select(bus.cpu_iorq_n, bus.cpu_m1_n, bus.cpu_wr_n);
          bufout_d   = ~bus.cpu_wr_n & ~iack_s;
          adrstb_n_d = 1'b0;
          cnt_d      = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (!req_s) begin
          state_d    = ST_RECOV;
          cm_d       = CM_NONE;
          adrstb_n_d = 1'b1;
          datstb_n_d = 1'b1;
          bufout_d   = 1'b0;
          cnt_d      = 4'd0;
        end else if (cnt_q == SETUP_LAST) begin
          state_d    = ST_DATA;
          datstb_n_d = 1'b0;
          cnt_d      = 4'd0;
`ifdef HC21_STE_TIMEOUT_EN
          tmo_d      = 8'd0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DATA: begin
        // A simultaneous TFRERR* and DATACK* is treated as an error.
        if (!req_s) begin
          state_d    = ST_RECOV;
          cm_d       = CM_NONE;
          adrstb_n_d = 1'b1;
          datstb_n_d = 1'b1;
          bufout_d   = 1'b0;
          cnt_d      = 4'd0;
        end else if (!err_s) begin
          state_d    = ST_END;
          datstb_n_d = 1'b1;
          cnt_d      = 4'd0;
          err_set_s  = 1'b1;
        end else if (!ack_s) begin
          state_d    = ST_END;
          datstb_n_d = 1'b1;
          cnt_d      = 4'd0;
        end else begin
`ifdef HC21_STE_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            state_d    = ST_END;
            datstb_n_d = 1'b1;
            cnt_d      = 4'd0;
            err_set_s  = 1'b1;
          end else if (tmo_q != 8'hFF) begin
            tmo_d = tmo_q + 8'd1;
          end else begin
            tmo_d = tmo_q;
          end
`else
          state_d = ST_DATA;
`endif
        end
      end
      ST_END: begin
        if (cnt_q == HOLD_LAST) begin
          state_d    = ST_RECOV;
          cm_d       = CM_NONE;
          adrstb_n_d = 1'b1;
          bufout_d   = 1'b0;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RECOV: begin
        // Wait for the CPU to finish and the slave to withdraw its reply.
        if (!req_s && ack_s && err_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOV;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cm_d       = CM_NONE;
        adrstb_n_d = 1'b1;
        datstb_n_d = 1'b1;
        bufout_d   = 1'b0;
        cnt_d      = 4'd0;
      end
    endcase

    if (err_set_s) begin
      bus_err_d = 1'b1;
    end else if (bus.err_clr) begin
      bus_err_d = 1'b0;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      cm_q       <= CM_NONE;
      adrstb_n_q <= 1'b1;
      datstb_n_q <= 1'b1;
      bufout_q   <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef HC21_STE_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cm_q       <= cm_d;
      adrstb_n_q <= adrstb_n_d;
      datstb_n_q <= datstb_n_d;
      bufout_q   <= bufout_d;
      bus_err_q  <= bus_err_d;
`ifdef HC21_STE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // WAIT* follows req combinationally so the Z80 is stalled in the cycle it asks.
  assign bus.cpu_wait_n   = ~(req_s & reset_n &
                              ((state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA)));
  assign bus.ste_cm       = cm_q;
  assign bus.ste_adrstb_n = adrstb_n_q;
  assign bus.ste_datstb_n = datstb_n_q;
  assign bus.bufout       = bufout_q;
  assign bus.bus_err      = bus_err_q;

endmodule

// File: tb/tb_hc21_ste_cycle_ctrl.sv
// Directed, scoreboard-checked bench for hc21_ste_cycle_ctrl (SETUP=1, HOLD=2, TIMEOUT=8).
module tb_hc21_ste_cycle_ctrl;

  localparam int SETUP = 1;
  localparam int HOLD  = 2;
  localparam int TMO   = 8;
  // Reply seen on DATACK* reaches WAIT* after two synchronizer edges plus the state register.
  localparam int ACK_TO_WAIT = 3;
`ifdef HC21_STE_TIMEOUT_EN
  localparam bit NOREP_ERR = 1'b1;
`else
  localparam bit NOREP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] cm;
    logic       bufout;
  } exp_t;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  hc21_ste_cycle_ctrl_if bus ();

  hc21_ste_cycle_ctrl #(
    .SETUP_CYC(SETUP),
    .HOLD_CYC (HOLD)
`ifdef HC21_STE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cpu_idle();
    bus.cpu_mreq_n = 1'b1; bus.cpu_iorq_n = 1'b1; bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1; bus.cpu_m1_n   = 1'b1; bus.cpu_rfsh_n = 1'b1;
    bus.onboard_n  = 1'b1;
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 iack
  task automatic drive_cpu(input int kind);
    cpu_idle();
    case (kind)
      0: begin bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
      1: begin bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
      2: begin bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
      3: begin bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
      default: begin bus.cpu_iorq_n = 1'b0; bus.cpu_m1_n = 1'b0; end
    endcase
  endtask

  function automatic exp_t expect_of(input int kind);
    case (kind)
      0:       return exp_t'({3'b111, 1'b0});
      1:       return exp_t'({3'b110, 1'b1});
      2:       return exp_t'({3'b101, 1'b0});
      3:       return exp_t'({3'b100, 1'b1});
      default: return exp_t'({3'b010, 1'b0});
    endcase
  endfunction

  // reply: 0 DATACK*, 1 TFRERR*+DATACK* together, 2 nothing
  task automatic do_cycle(input string tag, input int kind, input int reply,
                          input bit hold_clr, input bit exp_err, input bit keep_ack);
    exp_t e;
    int   n;
    int   lat;
    bit   found;
    bit   aborted;
    aborted = 1'b0;
    step();
    drive_cpu(kind);
    sb.push_back(expect_of(kind));
    #1;
    chk({tag, "_wait_same"}, bus.cpu_wait_n, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.ste_adrstb_n === 1'b0) begin found = 1'b1; break; end
    end
    chk({tag, "_adrstb"}, found, 1'b1);
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'(4'b1111);
    chk({tag, "_cm"}, bus.ste_cm, e.cm);
    chk({tag, "_bufout"}, bus.bufout, e.bufout);
    n = 0;
    while (bus.ste_adrstb_n === 1'b0 && bus.ste_datstb_n === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk({tag, "_setup"}, n, SETUP);
    if (hold_clr) bus.err_clr = 1'b1;
    if (reply != 2) begin
      repeat (5) step();
      chk({tag, "_held"}, {bus.cpu_wait_n, bus.ste_datstb_n}, 2'b00);
      bus.ste_datack_n = 1'b0;
      if (reply == 1) bus.ste_tfrerr_n = 1'b0;
      lat = 0;
      for (int i = 0; i < 30; i++) begin
        step();
        if (bus.cpu_wait_n === 1'b1) begin lat = i + 1; break; end
      end
      chk({tag, "_wait_lat"}, lat, ACK_TO_WAIT);
      if (hold_clr) begin
        chk({tag, "_set_wins"}, bus.bus_err, 1'b1);
        bus.err_clr = 1'b0;
      end
    end else begin
`ifdef HC21_STE_TIMEOUT_EN
      n = 0;
      for (int i = 0; i < 300; i++) begin
        if (bus.ste_datstb_n !== 1'b0) break;
        n++;
        step();
      end
      chk({tag, "_tmo_len"}, n, TMO);
      chk({tag, "_tmo_wait"}, bus.cpu_wait_n, 1'b1);
`else
      n = 0;
      repeat (1000) begin
        step();
        if (bus.cpu_wait_n !== 1'b0 || bus.ste_datstb_n !== 1'b0) n++;
      end
      chk({tag, "_wait_1000"}, n, 0);
      cpu_idle();
      step();
      chk({tag, "_abort"}, {bus.ste_adrstb_n, bus.ste_datstb_n, bus.ste_cm, bus.bufout}, 6'b110000);
      aborted = 1'b1;
`endif
    end
    if (!aborted) begin
      chk({tag, "_datstb_rel"}, bus.ste_datstb_n, 1'b1);
      n = 0;
      while (bus.ste_adrstb_n === 1'b0 && n < 20) begin
        n++;
        step();
      end
      chk({tag, "_hold"}, n, HOLD);
      chk({tag, "_cm_idle"}, {bus.ste_cm, bus.bufout}, 4'b0000);
    end
    chk({tag, "_bus_err"}, bus.bus_err, exp_err);
    cpu_idle();
    if (!keep_ack) begin
      bus.ste_datack_n = 1'b1;
      bus.ste_tfrerr_n = 1'b1;
    end
    repeat (4) step();
  endtask

  initial begin
    int  n;
    bit  found;
    cpu_idle();
    bus.ste_datack_n = 1'b1;
    bus.ste_tfrerr_n = 1'b1;
    bus.err_clr      = 1'b0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_wait", bus.cpu_wait_n, 1'b1);
    chk("rst_cm", bus.ste_cm, 3'b000);
    chk("rst_strobes", {bus.ste_adrstb_n, bus.ste_datstb_n}, 2'b11);
    chk("rst_bufout_err", {bus.bufout, bus.bus_err}, 2'b00);
    step();
    reset_n = 1'b1;
    repeat (2) step();

    do_cycle("memrd", 0, 0, 1'b0, 1'b0, 1'b0);
    do_cycle("iowr_err", 3, 1, 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    chk("err_sticky", bus.bus_err, 1'b1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("err_clr", bus.bus_err, 1'b0);
    do_cycle("iord", 2, 0, 1'b0, 1'b0, 1'b0);

    // On-card target: nothing may appear on the backplane.
    drive_cpu(0);
    bus.onboard_n = 1'b0;
    n = 0;
    repeat (8) begin
      step();
      if (bus.ste_adrstb_n !== 1'b1 || bus.ste_datstb_n !== 1'b1 ||
          bus.cpu_wait_n !== 1'b1 || bus.ste_cm !== 3'b000) n++;
    end
    chk("onboard_quiet", n, 0);
    // Refresh with RD* also low, so only RFSH* keeps the request off.
    drive_cpu(0);
    bus.cpu_rfsh_n = 1'b0;
    n = 0;
    repeat (8) begin
      step();
      if (bus.ste_adrstb_n !== 1'b1 || bus.ste_datstb_n !== 1'b1 ||
          bus.cpu_wait_n !== 1'b1 || bus.ste_cm !== 3'b000) n++;
    end
    chk("rfsh_quiet", n, 0);
    cpu_idle();
    repeat (2) step();

    do_cycle("norep", 0, 2, 1'b0, NOREP_ERR, 1'b0);

    // Reset while DATSTB* is asserted.
    step();
    drive_cpu(0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.ste_datstb_n === 1'b0) begin found = 1'b1; break; end
    end
    chk("rstdata_reach", found, 1'b1);
    @(negedge sysclk);
    reset_n = 1'b0;
    #1;
    chk("rstdata_strobes", {bus.ste_adrstb_n, bus.ste_datstb_n, bus.cpu_wait_n}, 3'b111);
    chk("rstdata_cm_buf_err", {bus.ste_cm, bus.bufout, bus.bus_err}, 5'b00000);
    step();
    cpu_idle();
    bus.ste_datack_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    n = 0;
    repeat (8) begin
      step();
      if (bus.ste_adrstb_n !== 1'b1 || bus.cpu_wait_n !== 1'b1) n++;
    end
    chk("rstdata_no_start", n, 0);
    bus.ste_datack_n = 1'b1;
    repeat (3) step();

    // IACK then a memory write while the slave still holds DATACK*.
    do_cycle("iack", 4, 0, 1'b0, 1'b0, 1'b1);
    drive_cpu(1);
    n = 0;
    repeat (6) begin
      step();
      if (bus.ste_adrstb_n !== 1'b1) n++;
    end
    chk("recov_blocks", n, 0);
    cpu_idle();
    bus.ste_datack_n = 1'b1;
    repeat (4) step();
    do_cycle("memwr", 1, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
